// File: rtl/spi_arb_pkg.sv
// Shared definitions for the round-robin SPI sequencer: state encoding,
// SPI word width and the read-back word substituted on a watchdog timeout.
package spi_arb_pkg;

  localparam int SPI_WORD_W = 16;
  localparam logic [SPI_WORD_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/spi_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit after 'last', with wrap.
// Generic over the requester count so other arbiters can reuse it.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  // Scan offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_rr_arbiter.sv
// Round-robin sequencer sharing one 16-bit SPI engine among NUM_REQ clients.
// Define SPI_ARB_TIMEOUT_EN to add a watchdog on the WAIT_HI/WAIT_LO states.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [16*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [15:0]                rsp_data,
  output logic                       rsp_err,
  output logic                       spi_start,
  output logic [15:0]                spi_data_in,
  input  logic                       spi_busy,
  input  logic [15:0]                spi_data_out,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       arb_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [SPI_WORD_W-1:0]  rsp_data_q, rsp_data_d;
  logic                   spi_start_q, spi_start_d;
  logic [SPI_WORD_W-1:0]  spi_data_in_q, spi_data_in_d;
  logic [IDX_W-1:0]       gnt_id_q, gnt_id_d;
  logic                   arb_busy_q, arb_busy_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [SPI_WORD_W-1:0]  req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*SPI_WORD_W +: SPI_WORD_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (gnt_id_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_q, tmo_hit_d;
  logic             rsp_err_q, rsp_err_d;
  logic             tmo_expired;

  assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d       = state_q;
    req_ack_d     = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    spi_start_d   = 1'b0;
    spi_data_in_d = spi_data_in_q;
    gnt_id_d      = gnt_id_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    tmo_hit_d     = tmo_hit_q;
    rsp_err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The engine must be idle too, otherwise its previous job is still running.
        if (pick_valid && !spi_busy) begin
          gnt_id_d            = pick_idx;
          spi_data_in_d       = req_word[pick_idx];
          req_ack_d[pick_idx] = 1'b1;
          state_d             = LAUNCH;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_cnt_d           = '0;
          tmo_hit_d           = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        spi_start_d = 1'b1;
        state_d     = WAIT_HI;
      end
      WAIT_HI, WAIT_LO: begin
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (state_q == WAIT_HI && spi_busy) begin
          state_d = WAIT_LO;
        end else if (state_q == WAIT_LO && !spi_busy) begin
          rsp_data_d = spi_data_out;
          state_d    = RESP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_expired) begin
          rsp_data_d = TIMEOUT_DATA;
          tmo_hit_d  = 1'b1;
          state_d    = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid_d[gnt_id_q] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        rsp_err_d             = tmo_hit_q;
`endif
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ack_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      spi_start_q   <= 1'b0;
      spi_data_in_q <= '0;
      gnt_id_q      <= IDX_W'(NUM_REQ - 1);
      arb_busy_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      tmo_hit_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_ack_q     <= req_ack_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      spi_start_q   <= spi_start_d;
      spi_data_in_q <= spi_data_in_d;
      gnt_id_q      <= gnt_id_d;
      arb_busy_q    <= arb_busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      tmo_hit_q     <= tmo_hit_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign req_ack     = req_ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign spi_start   = spi_start_q;
  assign spi_data_in = spi_data_in_q;
  assign gnt_id      = gnt_id_q;
  assign arb_busy    = arb_busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed bench for spi_rr_arbiter with a nibble-reversing SPI engine model.
// Build with SPI_ARB_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_spi_rr_arbiter;

  localparam int N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          spi_start;
  logic [15:0]   spi_data_in;
  logic          spi_busy;
  logic [15:0]   spi_data_out;
  logic [1:0]    gnt_id;
  logic          arb_busy;

  spi_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out),
    .gnt_id       (gnt_id),
    .arb_busy     (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nib_rev(input logic [15:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

  // SPI engine model and event logs, all advanced from tick()
  int         cyc = 0;
  logic [N-1:0] hold;
  int         busy_len;
  bit         stuck;
  bit         m_busy;
  int         m_cnt;
  logic [15:0] m_word;
  int         busy_low_cyc;

  logic [N-1:0] ack_log [64];
  int           ack_cyc [64];
  int           ack_n;
  logic [N-1:0] rv_log  [64];
  logic [15:0]  rd_log  [64];
  logic         re_log  [64];
  int           rsp_cyc [64];
  int           rsp_n;
  logic [15:0]  start_word [64];
  int           start_cyc  [64];
  int           start_n;

  task automatic clear_logs();
    ack_n = 0;
    rsp_n = 0;
    start_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      m_busy   = 1'b0;
      spi_busy = 1'b0;
    end else if (m_busy && !stuck) begin
      m_cnt--;
      if (m_cnt == 0) begin
        spi_data_out = nib_rev(m_word);
        spi_busy     = 1'b0;
        m_busy       = 1'b0;
        busy_low_cyc = cyc;
      end
    end
    if (spi_start) begin
      if (start_n < 64) begin
        start_word[start_n] = spi_data_in;
        start_cyc[start_n]  = cyc;
      end
      start_n++;
      m_word   = spi_data_in;
      m_busy   = 1'b1;
      m_cnt    = busy_len;
      spi_busy = 1'b1;
    end
    if (req_ack != '0) begin
      if (ack_n < 64) begin
        ack_log[ack_n] = req_ack;
        ack_cyc[ack_n] = cyc;
      end
      ack_n++;
      req = req & ~(req_ack & ~hold);
    end
    if (rsp_valid != '0) begin
      if (rsp_n < 64) begin
        rv_log[rsp_n]  = rsp_valid;
        rd_log[rsp_n]  = rsp_data;
        re_log[rsp_n]  = rsp_err;
        rsp_cyc[rsp_n] = cyc;
      end
      $display("txn %0d @%0d: rsp_valid=%b rsp_data=%h rsp_err=%b gnt_id=%0d",
               rsp_n, cyc, rsp_valid, rsp_data, rsp_err, gnt_id);
      rsp_n++;
    end
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rsp_n < n; i++) tick();
    check_eq(tag, rsp_n, n);
  endtask

  task automatic check_reset_vals(input string p);
    check_eq({p, "_req_ack"},     req_ack, 0);
    check_eq({p, "_rsp_valid"},   rsp_valid, 0);
    check_eq({p, "_rsp_data"},    rsp_data, 0);
    check_eq({p, "_rsp_err"},     rsp_err, 0);
    check_eq({p, "_spi_start"},   spi_start, 0);
    check_eq({p, "_spi_data_in"}, spi_data_in, 0);
    check_eq({p, "_gnt_id"},      gnt_id, 3);
    check_eq({p, "_arb_busy"},    arb_busy, 0);
  endtask

  logic [N-1:0] exp_ack  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0]  exp_data [5] = '{16'h4321, 16'h3C5A, 16'hFEEB, 16'hEFAC, 16'h4321};

  int t0;

  initial begin
    reset = 1'b1; req = '0; req_data = '0; spi_busy = 1'b0; spi_data_out = '0;
    hold = '0; stuck = 1'b0; m_busy = 1'b0; busy_len = 4; busy_low_cyc = 0;
    clear_logs();
    tick(); tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Single request from requester 1
    clear_logs();
    busy_len = 40;
    req_data[31:16] = 16'hA5C3;
    req = 4'b0010;
    t0 = cyc;
    wait_rsp(1, 200, "single_rsp_n");
    check_eq("single_ack",       ack_log[0], 4'b0010);
    check_eq("single_ack_lat",   ack_cyc[0] - t0, 1);
    check_eq("single_start_n",   start_n, 1);
    check_eq("single_start_lat", start_cyc[0] - t0, 2);
    check_eq("single_spi_word",  start_word[0], 16'hA5C3);
    check_eq("single_rsp_valid", rv_log[0], 4'b0010);
    check_eq("single_rsp_data",  rd_log[0], 16'h3C5A);
    check_eq("single_rsp_err",   re_log[0], 0);
    check_eq("single_rsp_lat",   rsp_cyc[0] - busy_low_cyc, 2);
    check_eq("single_gnt_id",    gnt_id, 1);
    tick();
    check_eq("single_idle",      arb_busy, 0);

    // Requesters 0 and 2 together after last grant 1
    clear_logs();
    busy_len = 5;
    req_data[15:0]  = 16'h1234;
    req_data[47:32] = 16'hBEEF;
    req = 4'b0101;
    wait_rsp(2, 200, "simul_rsp_n");
    check_eq("simul_ack0",  ack_log[0], 4'b0100);
    check_eq("simul_ack1",  ack_log[1], 4'b0001);
    check_eq("simul_rv0",   rv_log[0], 4'b0100);
    check_eq("simul_rd0",   rd_log[0], 16'hFEEB);
    check_eq("simul_rv1",   rv_log[1], 4'b0001);
    check_eq("simul_rd1",   rd_log[1], 16'h4321);
    check_eq("simul_gap",   ack_cyc[1] - rsp_cyc[0], 1);

    // All four continuously requesting from reset
    reset = 1'b1; tick(); reset = 1'b0;
    clear_logs();
    busy_len = 3;
    req_data = {16'hCAFE, 16'hBEEF, 16'hA5C3, 16'h1234};
    hold = 4'b1111;
    req  = 4'b1111;
    wait_rsp(5, 400, "all_rsp_n");
    req = '0; hold = '0;
    check_eq("all_ack_n", ack_n, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("all_ack%0d", i), ack_log[i], exp_ack[i]);
      check_eq($sformatf("all_rv%0d", i),  rv_log[i],  exp_ack[i]);
      check_eq($sformatf("all_rd%0d", i),  rd_log[i],  exp_data[i]);
    end
    tick();

    // Request raised while busy waits for the current response
    clear_logs();
    busy_len = 10;
    req = 4'b0010;
    repeat (4) tick();
    req = req | 4'b1000;
    wait_rsp(2, 200, "held_rsp_n");
    check_eq("held_ack_n",  ack_n, 2);
    check_eq("held_ack1",   ack_log[1], 4'b1000);
    check_eq("held_gap",    ack_cyc[1] - rsp_cyc[0], 1);
    check_eq("held_rd1",    rd_log[1], 16'hEFAC);

    // Reset while the engine is busy (WAIT_LO)
    tick();
    clear_logs();
    busy_len = 20;
    req_data[15:0] = 16'h8001;
    req = 4'b0001;
    repeat (10) tick();
    check_eq("rst_mid_busy", arb_busy, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (40) tick();
    check_eq("rst_no_rsp", rsp_n, 0);
    clear_logs();
    busy_len = 4;
    req_data[63:48] = 16'h0F0F;
    req = 4'b1001;
    wait_rsp(2, 200, "rst_rsp_n");
    check_eq("rst_ack0", ack_log[0], 4'b0001);
    check_eq("rst_rd0",  rd_log[0], 16'h1008);
    check_eq("rst_ack1", ack_log[1], 4'b1000);
    check_eq("rst_rd1",  rd_log[1], 16'hF0F0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Engine stuck busy: watchdog answers with FFFF and rsp_err
    tick();
    clear_logs();
    stuck = 1'b1;
    req_data[47:32] = 16'h1111;
    req = 4'b0100;
    wait_rsp(1, 100, "tmo_rsp_n");
    check_eq("tmo_rv",  rv_log[0], 4'b0100);
    check_eq("tmo_rd",  rd_log[0], 16'hFFFF);
    check_eq("tmo_err", re_log[0], 1);
    check_eq("tmo_lat", rsp_cyc[0] - start_cyc[0], TMO + 1);
    tick();
    check_eq("tmo_idle", arb_busy, 0);
    check_eq("tmo_err_clr", rsp_err, 0);
    stuck = 1'b0; m_busy = 1'b0; spi_busy = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
